// File: rtl/pipe_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_skid_stage : valid/ready pipeline stage with optional skid entry,   |
// |                   synchronous flush and saturating discard counter.      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module pipe_skid_stage #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int                SKID       = 1,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  discard_cnt
);

  logic       acc;
  logic       pop;
  logic [1:0] kill_cnt;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
      } state_t;

      state_t            state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;

      always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        kill_cnt = 2'd0;
        if (flush) begin
          state_d  = EMPTY;
          main_d   = RESET_DATA;
          skid_d   = RESET_DATA;
          // A main entry leaving downstream this cycle is delivered, not killed
          kill_cnt = {1'b0, state_q == FULL} + {1'b0, out_valid & ~out_ready};
        end else begin
          unique case (state_q)
            EMPTY: begin
              if (acc) begin
                state_d = ONE;
                main_d  = in_data;
              end
            end
            ONE: begin
              if (acc && pop) begin
                main_d = in_data;
              end else if (acc) begin
                state_d = FULL;
                skid_d  = in_data;
              end else if (pop) begin
                state_d = EMPTY;
                main_d  = RESET_DATA;
              end
            end
            FULL: begin
              if (pop) begin
                state_d = ONE;
                main_d  = skid_q;
                skid_d  = RESET_DATA;
              end
            end
            default: begin
              state_d = EMPTY;
              main_d  = RESET_DATA;
              skid_d  = RESET_DATA;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= EMPTY;
          main_q  <= RESET_DATA;
          skid_q  <= RESET_DATA;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      // Ready depends only on registered state, cutting the out_ready path
      assign in_ready  = (state_q != FULL);
      assign out_valid = (state_q != EMPTY);
      assign out_data  = main_q;
      assign occupancy = state_q;
    end else begin : g_noskid
      logic              main_valid_q, main_valid_d;
      logic [DATA_W-1:0] main_q, main_d;

      always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        kill_cnt     = 2'd0;
        if (flush) begin
          main_valid_d = 1'b0;
          main_d       = RESET_DATA;
          kill_cnt     = {1'b0, main_valid_q & ~out_ready};
        end else if (acc) begin
          main_valid_d = 1'b1;
          main_d       = in_data;
        end else if (pop) begin
          main_valid_d = 1'b0;
          main_d       = RESET_DATA;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          main_valid_q <= 1'b0;
          main_q       <= RESET_DATA;
        end else begin
          main_valid_q <= main_valid_d;
          main_q       <= main_d;
        end
      end

      assign in_ready  = ~main_valid_q | out_ready;
      assign out_valid = main_valid_q;
      assign out_data  = main_q;
      assign occupancy = {1'b0, main_valid_q};
    end
  endgenerate

  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    cnt_sum       = {1'b0, discard_cnt_q} + (CNT_W+1)'(kill_cnt);
    discard_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt_q <= '0;
    end else begin
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign discard_cnt = discard_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_skid_stage : directed vector table plus randomized traffic for   |
// |                      skid (SKID=1, two counter widths) and SKID=0 stages. |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, mode0;
  logic [15:0] in_data;
  logic        ab_in_valid, c_in_valid;

  logic        a_rdy, a_ov, b_rdy, b_ov, c_rdy, c_ov;
  logic [15:0] a_od, b_od, c_od;
  logic [1:0]  a_occ, b_occ, c_occ;
  logic [15:0] a_cnt, c_cnt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  assign ab_in_valid = in_valid & ~mode0;
  assign c_in_valid  = in_valid & mode0;

  pipe_skid_stage #(.DATA_W(16), .RESET_DATA(16'h0), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(ab_in_valid), .in_ready(a_rdy),
    .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .occupancy(a_occ), .discard_cnt(a_cnt));

  pipe_skid_stage #(.DATA_W(16), .RESET_DATA(16'h0), .SKID(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(ab_in_valid), .in_ready(b_rdy),
    .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .occupancy(b_occ), .discard_cnt(b_cnt));

  pipe_skid_stage #(.DATA_W(16), .RESET_DATA(16'h0), .SKID(0), .CNT_W(16)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(c_in_valid), .in_ready(c_rdy),
    .in_data(in_data), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .occupancy(c_occ), .discard_cnt(c_cnt));

  logic        act_rdy, act_ov;
  logic [15:0] act_od, act_cnt;
  logic [1:0]  act_occ;
  assign act_rdy = mode0 ? c_rdy : a_rdy;
  assign act_ov  = mode0 ? c_ov  : a_ov;
  assign act_od  = mode0 ? c_od  : a_od;
  assign act_occ = mode0 ? c_occ : a_occ;
  assign act_cnt = mode0 ? c_cnt : a_cnt;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s (mode0=%0d t=%0t): got %0h expected %0h", nm, mode0, $time, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 2 (skid) or 1 (no skid)
  logic [15:0] mq[$];
  int unsigned mcnt = 0;
  bit          m_acc;

  function automatic logic exp_rdy();
    if (mode0) return (mq.size() == 0) || out_ready;
    return mq.size() < 2;
  endfunction

  task automatic check_model();
    logic [15:0] ed;
    ed = (mq.size() != 0) ? mq[0] : 16'h0;
    chk("m_in_ready", {31'd0, act_rdy}, {31'd0, exp_rdy()});
    chk("m_out_valid", {31'd0, act_ov}, (mq.size() != 0) ? 1 : 0);
    chk("m_out_data", {16'd0, act_od}, {16'd0, ed});
    chk("m_occupancy", {30'd0, act_occ}, mq.size());
    chk("m_discard", {16'd0, act_cnt}, (mcnt > 65535) ? 65535 : mcnt);
    if (!mode0) chk("m_discard_sat", {30'd0, b_cnt}, (mcnt > 3) ? 3 : mcnt);
  endtask

  task automatic advance();
    bit pop;
    @(posedge clk);
    pop   = (mq.size() != 0) && out_ready;
    m_acc = in_valid && exp_rdy();
    if (reset) begin
      mq.delete();
      mcnt = 0;
    end else if (flush) begin
      mcnt += mq.size() - (pop ? 1 : 0);
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic fl, input logic iv,
                       input logic [15:0] d, input logic ordy);
    reset = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  typedef struct {
    bit          m0;
    logic        rst, fl, iv;
    logic [15:0] d;
    logic        ordy;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  occ;
    logic        rdy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit m0, input logic rst, input logic fl, input logic iv,
                     input logic [15:0] d, input logic ordy, input logic ov,
                     input logic [15:0] od, input logic [1:0] occ, input logic rdy,
                     input logic [15:0] cnt);
    vec_t v;
    v.m0 = m0; v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.rdy = rdy; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic run_table(input bit sel);
    mode0 = sel;
    foreach (tbl[i]) begin
      if (tbl[i].m0 == sel) begin
        drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
        #1;
        chk("t_in_ready", {31'd0, act_rdy}, {31'd0, tbl[i].rdy});
        chk("t_out_valid", {31'd0, act_ov}, {31'd0, tbl[i].ov});
        chk("t_out_data", {16'd0, act_od}, {16'd0, tbl[i].od});
        chk("t_occupancy", {30'd0, act_occ}, {30'd0, tbl[i].occ});
        chk("t_discard", {16'd0, act_cnt}, {16'd0, tbl[i].cnt});
        check_model();
        advance();
      end
    end
  endtask

  task automatic run_random(input bit sel, input int cycles);
    bit          pend = 0;
    logic [15:0] pend_d = 16'h0;
    logic        r, fl, iv, ordy;
    logic [15:0] d;
    mode0 = sel;
    for (int i = 0; i < cycles; i++) begin
      r    = ($urandom % 64) == 0;
      fl   = ($urandom % 12) == 0;
      iv   = pend ? 1'b1 : (($urandom % 4) != 0);
      d    = pend ? pend_d : 16'($urandom);
      ordy = ($urandom % 3) != 0;
      drive(r, fl, iv, d, ordy);
      #1;
      check_model();
      advance();
      pend   = iv && !m_acc && !r;
      pend_d = d;
    end
  endtask

  task automatic reset_cycle();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    #1;
    advance();
  endtask

  initial begin
    // streaming
    add(0,0,0,1,16'h1,1, 0,16'h0,0,1,0);
    for (int k = 2; k <= 8; k++) add(0,0,0,1,16'(k),1, 1,16'(k-1),1,1,0);
    add(0,0,0,0,16'h0,1, 1,16'h8,1,1,0);
    add(0,0,0,0,16'h0,1, 0,16'h0,0,1,0);
    // backpressure
    add(0,0,0,1,16'hA,0, 0,16'h0,0,1,0);
    add(0,0,0,1,16'hB,0, 1,16'hA,1,1,0);
    add(0,0,0,0,16'h0,0, 1,16'hA,2,0,0);
    add(0,0,0,0,16'h0,1, 1,16'hA,2,0,0);
    add(0,0,0,0,16'h0,1, 1,16'hB,1,1,0);
    add(0,0,0,0,16'h0,0, 0,16'h0,0,1,0);
    // flush of a full stage, then flush racing an accept
    add(0,0,0,1,16'h11,0, 0,16'h0,0,1,0);
    add(0,0,0,1,16'h12,0, 1,16'h11,1,1,0);
    add(0,0,1,1,16'hC,0,  1,16'h11,2,0,0);
    add(0,0,0,0,16'h0,0,  0,16'h0,0,1,2);
    add(0,0,1,1,16'hE,0,  0,16'h0,0,1,2);
    add(0,0,0,0,16'h0,1,  0,16'h0,0,1,2);
    // flush together with a pop
    add(0,0,0,1,16'hD,0,  0,16'h0,0,1,2);
    add(0,0,1,0,16'h0,1,  1,16'hD,1,1,2);
    add(0,0,0,0,16'h0,0,  0,16'h0,0,1,2);
    add(0,0,0,1,16'h21,0, 0,16'h0,0,1,2);
    add(0,0,0,1,16'h22,0, 1,16'h21,1,1,2);
    add(0,0,1,0,16'h0,1,  1,16'h21,2,0,2);
    add(0,0,0,0,16'h0,0,  0,16'h0,0,1,3);
    // third kill pushes the 2-bit counter past saturation
    add(0,0,0,1,16'h31,0, 0,16'h0,0,1,3);
    add(0,0,0,1,16'h32,0, 1,16'h31,1,1,3);
    add(0,0,1,0,16'h0,0,  1,16'h31,2,0,3);
    add(0,0,0,0,16'h0,0,  0,16'h0,0,1,5);
    // reset beats flush, then reset drops an in-flight payload
    add(0,1,1,1,16'h41,0, 0,16'h0,0,1,5);
    add(0,0,0,0,16'h0,0,  0,16'h0,0,1,0);
    add(0,0,0,1,16'h51,0, 0,16'h0,0,1,0);
    add(0,1,0,0,16'h0,0,  1,16'h51,1,1,0);
    add(0,0,0,0,16'h0,0,  0,16'h0,0,1,0);
    // single-entry stage
    add(1,0,0,1,16'h61,0, 0,16'h0,0,1,0);
    add(1,0,0,1,16'h62,0, 1,16'h61,1,0,0);
    add(1,0,0,1,16'h62,1, 1,16'h61,1,1,0);
    add(1,0,0,1,16'h63,1, 1,16'h62,1,1,0);
    add(1,0,0,0,16'h0,1,  1,16'h63,1,1,0);
    add(1,0,0,0,16'h0,0,  0,16'h0,0,1,0);
    add(1,0,0,1,16'h64,0, 0,16'h0,0,1,0);
    add(1,0,1,0,16'h0,0,  1,16'h64,1,0,0);
    add(1,0,0,0,16'h0,0,  0,16'h0,0,1,1);

    mode0 = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    mq.delete();
    mcnt = 0;

    run_table(1'b0);
    run_random(1'b0, 600);
    reset_cycle();
    mode0 = 1'b1;
    reset_cycle();
    run_table(1'b1);
    run_random(1'b1, 600);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
